// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: default datapath widths and the fetch-queue entry payload.
package cpu_pkg;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned INSTR_W = 32;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc_plus1;
   } fq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO over an arbitrary packed entry type, with a single-cycle flush.
module sync_fifo
   import cpu_pkg::*;
#(
   parameter type         T     = fq_entry_t,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  T              push_data,
   input  logic          pop,
   output T              head,
   output logic [CW-1:0] count
);

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   T              mem [DEPTH];

   // Storage is cleared on reset so the head reads as zero while idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   assign head = mem[rd_ptr];

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(push && !pop && !flush && (count == CW'(DEPTH))));

   a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
      !(pop && !flush && (count == '0)));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues 1-cycle-latency reads and
// buffers returned instructions for decode; a taken branch flushes and redirects.
module fetch_queue #(
   parameter int unsigned     PC_W     = cpu_pkg::PC_W,
   parameter int unsigned     INSTR_W  = cpu_pkg::INSTR_W,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pc_src_i,
   input  logic [PC_W-1:0]            pc_branch_i,
   output logic                       imem_req_o,
   output logic [PC_W-1:0]            imem_addr_o,
   input  logic [INSTR_W-1:0]         imem_rdata_i,
   output logic [INSTR_W-1:0]         instr_o,
   output logic [PC_W-1:0]            pc_plus1_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 1;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc_plus1;
   } entry_t;

   logic [PC_W-1:0] fetch_pc;
   logic [PC_W-1:0] inflight_pc;
   logic            inflight;
   logic            kill;
   logic            req;
   logic            enq;
   logic            deq;
   logic [CW-1:0]   count;
   entry_t          enq_data;
   entry_t          head;

   // Credit check counts the outstanding read but not a same-cycle dequeue.
   assign req = reset & ~pc_src_i & ((SW'(count) + SW'(inflight)) < SW'(DEPTH));
   assign enq = inflight & ~kill & ~pc_src_i;
   assign deq = valid_o & ready_i;

   assign enq_data.instr    = imem_rdata_i;
   assign enq_data.pc_plus1 = inflight_pc + PC_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         inflight_pc <= '0;
         inflight    <= 1'b0;
         kill        <= 1'b0;
      end else begin
         kill     <= pc_src_i & inflight;
         inflight <= req;
         if (req) begin
            inflight_pc <= fetch_pc;
         end
         if (pc_src_i) begin
            fetch_pc <= pc_branch_i;
         end else if (req) begin
            fetch_pc <= fetch_pc + PC_W'(1);
         end
      end
   end

   sync_fifo #(
      .T     (entry_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (pc_src_i),
      .push      (enq),
      .push_data (enq_data),
      .pop       (deq),
      .head      (head),
      .count     (count)
   );

   assign imem_req_o  = req;
   assign imem_addr_o = fetch_pc;
   assign valid_o     = (count != '0) & ~pc_src_i;
   assign instr_o     = head.instr;
   assign pc_plus1_o  = head.pc_plus1;
   assign count_o     = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, corner sequences and
// random traffic against a queue-based reference model.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        pc_src_i;
   logic [31:0] pc_branch_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic [31:0] instr_o;
   logic [31:0] pc_plus1_o;
   logic        valid_o;
   logic        ready_i;
   logic [2:0]  count_o;

   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_rdata;
   logic [31:0] w_instr;
   logic [31:0] w_pc1;
   logic        w_valid;
   logic [2:0]  w_count;

   int n_chk;
   int n_fail;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_src_i     (pc_src_i),
      .pc_branch_i  (pc_branch_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_rdata_i (imem_rdata_i),
      .instr_o      (instr_o),
      .pc_plus1_o   (pc_plus1_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .count_o      (count_o)
   );

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFE)) dut_wrap (
      .clk          (clk),
      .reset        (reset),
      .pc_src_i     (1'b0),
      .pc_branch_i  (32'h0),
      .imem_req_o   (w_req),
      .imem_addr_o  (w_addr),
      .imem_rdata_i (w_rdata),
      .instr_o      (w_instr),
      .pc_plus1_o   (w_pc1),
      .valid_o      (w_valid),
      .ready_i      (1'b1),
      .count_o      (w_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // Instruction memory: one-cycle read latency, garbage when not requested.
   always @(posedge clk) begin
      imem_rdata_i <= imem_req_o ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
      w_rdata      <= w_req ? mem_word(w_addr) : 32'hDEAD_BEEF;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: fetch PC, the one outstanding read, and a queue of delivered PCs.
   logic [31:0] m_pc;
   bit          m_pend;
   logic [31:0] m_pend_pc;
   logic [31:0] m_q[$];
   bit          e_req, e_vld, t_src, t_rdy;
   logic [31:0] t_tgt;

   task automatic do_reset();
      reset    = 1'b0;
      pc_src_i = 1'b0;
      pc_branch_i = '0;
      ready_i  = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      m_pc   = 32'h0;
      m_pend = 1'b0;
      m_q.delete();
   endtask

   task automatic tick_begin(input bit src, input logic [31:0] tgt, input bit rdy);
      t_src = src; t_tgt = tgt; t_rdy = rdy;
      pc_src_i = src; pc_branch_i = tgt; ready_i = rdy;
      e_req = !src && (m_q.size() + int'(m_pend) < int'(DEPTH));
      e_vld = !src && (m_q.size() != 0);
      @(negedge clk);
      chk("req", 32'(imem_req_o), 32'(e_req));
      if (e_req) chk("addr", imem_addr_o, m_pc);
      chk("valid", 32'(valid_o), 32'(e_vld));
      chk("count", 32'(count_o), 32'(m_q.size()));
      if (e_vld) begin
         chk("pc_plus1", pc_plus1_o, m_q[0] + 32'd1);
         chk("instr", instr_o, mem_word(m_q[0]));
      end
   endtask

   task automatic tick_end();
      @(posedge clk);
      if (t_src) begin
         m_q.delete();
         m_pend = 1'b0;
         m_pc   = t_tgt;
      end else begin
         if (e_vld && t_rdy) void'(m_q.pop_front());
         if (m_pend) m_q.push_back(m_pend_pc);
         m_pend = e_req;
         if (e_req) begin
            m_pend_pc = m_pc;
            m_pc      = m_pc + 32'd1;
         end
      end
      #1;
   endtask

   task automatic tick(input bit src, input logic [31:0] tgt, input bit rdy);
      tick_begin(src, tgt, rdy);
      tick_end();
   endtask

   typedef struct {
      bit          rst;
      bit          rdy;
      bit          req;
      logic [31:0] addr;
      bit          vld;
      logic [31:0] pc1;
      int          cnt;
   } vec_t;

   vec_t vt [21];

   initial begin
      logic [31:0] e;
      int          seen;
      bit          ok_stream;

      n_chk  = 0;
      n_fail = 0;

      // {rst, ready, req, addr, valid, pc_plus1, count}; stream from reset, then backpressure
      vt[0]  = '{1, 1, 1, 0, 0, 0, 0};
      vt[1]  = '{0, 1, 1, 1, 0, 0, 0};
      vt[2]  = '{0, 1, 1, 2, 1, 1, 1};
      vt[3]  = '{0, 1, 1, 3, 1, 2, 1};
      vt[4]  = '{0, 1, 1, 4, 1, 3, 1};
      vt[5]  = '{0, 1, 1, 5, 1, 4, 1};
      vt[6]  = '{1, 0, 1, 0, 0, 0, 0};
      vt[7]  = '{0, 0, 1, 1, 0, 0, 0};
      vt[8]  = '{0, 0, 1, 2, 1, 1, 1};
      vt[9]  = '{0, 0, 1, 3, 1, 1, 2};
      vt[10] = '{0, 0, 0, 0, 1, 1, 3};
      for (int i = 11; i <= 15; i++) vt[i] = '{0, 0, 0, 0, 1, 1, 4};
      vt[16] = '{0, 1, 0, 0, 1, 1, 4};
      vt[17] = '{0, 1, 1, 4, 1, 2, 3};
      vt[18] = '{0, 1, 1, 5, 1, 3, 2};
      vt[19] = '{0, 1, 1, 6, 1, 4, 2};
      vt[20] = '{0, 1, 1, 7, 1, 5, 2};

      for (int i = 0; i < 21; i++) begin
         if (vt[i].rst) do_reset();
         pc_src_i = 1'b0;
         ready_i  = vt[i].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d_req", i), 32'(imem_req_o), 32'(vt[i].req));
         if (vt[i].req) chk($sformatf("vec%0d_addr", i), imem_addr_o, vt[i].addr);
         chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vt[i].vld));
         if (vt[i].vld) begin
            chk($sformatf("vec%0d_pc1", i), pc_plus1_o, vt[i].pc1);
            chk($sformatf("vec%0d_instr", i), instr_o, mem_word(vt[i].pc1 - 32'd1));
         end
         chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(vt[i].cnt));
         @(posedge clk);
         #1;
      end

      // PC wrap on the second instance
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) chk("wrap_count0", 32'(w_count), 32'd0);
         if (k < 3) begin
            e = 32'hFFFF_FFFE + 32'(k);
            chk("wrap_req", 32'(w_req), 32'd1);
            chk("wrap_addr", w_addr, e);
         end
         if (k >= 2) begin
            e = 32'hFFFF_FFFF + 32'(k - 2);
            chk("wrap_valid", 32'(w_valid), 32'd1);
            chk("wrap_pc1", w_pc1, e);
            chk("wrap_instr", w_instr, mem_word(e - 32'd1));
         end
         @(posedge clk);
         #1;
      end

      // Redirect with three queued entries and a read outstanding
      do_reset();
      repeat (4) tick(1'b0, 32'h0, 1'b0);
      tick_begin(1'b1, 32'h40, 1'b0);
      chk("redir_cnt_before", 32'(count_o), 32'd3);
      chk("redir_req", 32'(imem_req_o), 32'd0);
      chk("redir_valid", 32'(valid_o), 32'd0);
      tick_end();
      tick_begin(1'b0, 32'h0, 1'b1);
      chk("redir_cnt_after", 32'(count_o), 32'd0);
      chk("redir_addr_t1", imem_addr_o, 32'h40);
      chk("redir_req_t1", 32'(imem_req_o), 32'd1);
      tick_end();
      tick_begin(1'b0, 32'h0, 1'b1);
      chk("redir_valid_t2", 32'(valid_o), 32'd0);
      tick_end();
      tick_begin(1'b0, 32'h0, 1'b1);
      chk("redir_valid_t3", 32'(valid_o), 32'd1);
      chk("redir_pc1_t3", pc_plus1_o, 32'h41);
      chk("redir_instr_t3", instr_o, mem_word(32'h40));
      tick_end();

      // Back-to-back redirects: only the 0x20 stream reaches decode
      do_reset();
      repeat (5) tick(1'b0, 32'h0, 1'b1);
      tick(1'b1, 32'h10, 1'b1);
      tick_begin(1'b1, 32'h20, 1'b1);
      chk("b2b_req", 32'(imem_req_o), 32'd0);
      tick_end();
      tick_begin(1'b0, 32'h0, 1'b1);
      chk("b2b_addr", imem_addr_o, 32'h20);
      tick_end();
      seen = 0;
      ok_stream = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick_begin(1'b0, 32'h0, 1'b1);
         if (valid_o) begin
            if (pc_plus1_o !== 32'h21 + 32'(seen)) ok_stream = 1'b0;
            seen++;
         end
         tick_end();
      end
      chk("b2b_stream_order", 32'(ok_stream), 32'd1);
      chk("b2b_delivered", 32'(seen), 32'd9);

      // Asynchronous reset between edges, mid-stream
      do_reset();
      repeat (6) tick(1'b0, 32'h0, 1'b1);
      #3 reset = 1'b0;
      #1;
      chk("arst_req", 32'(imem_req_o), 32'd0);
      chk("arst_valid", 32'(valid_o), 32'd0);
      chk("arst_count", 32'(count_o), 32'd0);
      chk("arst_instr", instr_o, 32'd0);
      chk("arst_pc1", pc_plus1_o, 32'd0);
      @(posedge clk);
      #3 reset = 1'b1;
      m_pc   = 32'h0;
      m_pend = 1'b0;
      m_q.delete();
      tick_begin(1'b0, 32'h0, 1'b1);
      chk("arst_restart_addr", imem_addr_o, 32'h0);
      tick_end();
      tick(1'b0, 32'h0, 1'b1);
      tick_begin(1'b0, 32'h0, 1'b1);
      chk("arst_first_pc1", pc_plus1_o, 32'h1);
      tick_end();
      repeat (5) tick(1'b0, 32'h0, 1'b1);

      // Random traffic against the model
      do_reset();
      for (int k = 0; k < 600; k++) begin
         logic [31:0] tgt;
         bit          src;
         bit          rdy;
         src = ($urandom_range(0, 19) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                           : 32'($urandom);
         tick(src, tgt, rdy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
